line_packer: RTL and testbench

//  Pixel-to-line packer: collects 24-bit RGB pixels from the pixel pipeline and packs them

---
 rtl/line_packer.sv | 139 +++++++++++++
 tb/tb_line_packer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_packer.sv
// ---------------------------------------------------------------------------
// line_packer
//   Packs 24-bit pixels into 512-bit line words. Pixel k of a word lands in
//   bits [DATA_W*k +: DATA_W], with k=0 at the LSB. A word is closed either
//   when all PIX_PER_WORD slots are filled or when a pixel tagged i_last is
//   taken. Slots that were never written are zero. The write side is the
//   counterpart of the line unpacker.
//
//   There is one assembly register and one output register. A finished word
//   that cannot move to the output register is parked in the assembly
//   register. While it is parked, o_ready is deasserted.
//
//   Optional feature (macro LINE_PACK_TAG_EN):
//     defined   : o_lineImg[LINE_W-1 : DATA_W*PIX_PER_WORD] holds the
//                 number of valid pixels in the word (1..PIX_PER_WORD).
//     undefined : those bits are constant zero.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   i_pix      in   [DATA_W-1:0] input pixel
//   i_valid    in   i_pix valid
//   i_last     in   i_pix is the last pixel of an image line
//   o_ready    out  packer accepts i_pix this cycle
//   o_lineImg  out  [LINE_W-1:0] packed word
//   o_valid    out  o_lineImg valid
//   o_lineEnd  out  word holds the last pixel of a line
//   i_ready    in   downstream accepts o_lineImg this cycle
// ---------------------------------------------------------------------------
module line_packer #(
    parameter int DATA_W = 24,
    parameter int LINE_W = 512
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] i_pix,
    input  logic              i_valid,
    input  logic              i_last,
    output logic              o_ready,
    output logic [LINE_W-1:0] o_lineImg,
    output logic              o_valid,
    output logic              o_lineEnd,
    input  logic              i_ready
);

    localparam int PIX_PER_WORD = LINE_W / DATA_W;
    localparam int DATA_BITS    = DATA_W * PIX_PER_WORD;
    localparam int TAG_W        = LINE_W - DATA_BITS;
    localparam int CNT_W        = $clog2(PIX_PER_WORD + 1);

    logic [DATA_BITS-1:0] asm_q;
    logic [CNT_W-1:0]     cnt_q;       // pixels in asm_q (also valid while pending)
    logic                 pending_q;
    logic                 pend_last_q;

    logic [LINE_W-1:0]    img_q;
    logic                 valid_q;
    logic                 line_end_q;

    logic                 out_free;
    logic                 accept;
    logic                 complete;
    logic                 load_new;
    logic                 load_pend;
    logic                 load;
    logic [DATA_BITS-1:0] merged;
    logic [DATA_BITS-1:0] load_data;
    logic                 load_last;
    logic [TAG_W-1:0]     tag;

    assign out_free  = !valid_q || i_ready;
    assign accept    = i_valid && !pending_q;
    assign complete  = accept && ((cnt_q == CNT_W'(PIX_PER_WORD - 1)) || i_last);
    assign load_new  = complete && out_free;
    assign load_pend = pending_q && out_free;
    assign load      = load_new || load_pend;

    // Slots above cnt_q are still zero, so replacing the selected slot is
    // the same as OR-ing the pixel in.
    for (genvar k = 0; k < PIX_PER_WORD; k++) begin : g_slot
        assign merged[k*DATA_W +: DATA_W] =
            (cnt_q == CNT_W'(k)) ? i_pix : asm_q[k*DATA_W +: DATA_W];
    end

    assign load_data = pending_q ? asm_q : merged;
    assign load_last = pending_q ? pend_last_q : i_last;

`ifdef LINE_PACK_TAG_EN
    // A parked word already counts its closing pixel. A word closing in this
    // cycle adds one for the pixel being taken now.
    logic [CNT_W-1:0] load_cnt;
    assign load_cnt = pending_q ? cnt_q : (cnt_q + CNT_W'(1));
    assign tag      = TAG_W'(load_cnt);
`else
    assign tag      = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            asm_q       <= '0;
            cnt_q       <= '0;
            pending_q   <= 1'b0;
            pend_last_q <= 1'b0;
            img_q       <= '0;
            valid_q     <= 1'b0;
            line_end_q  <= 1'b0;
        end else begin
            // Output register
            if (load) begin
                img_q      <= {tag, load_data};
                line_end_q <= load_last;
                valid_q    <= 1'b1;
            end else if (i_ready) begin
                valid_q    <= 1'b0;
            end

            // Assembly register
            if (load) begin
                asm_q       <= '0;
                cnt_q       <= '0;
                pending_q   <= 1'b0;
                pend_last_q <= 1'b0;
            end else if (accept) begin
                asm_q <= merged;
                cnt_q <= cnt_q + CNT_W'(1);
                if (complete) begin
                    pending_q   <= 1'b1;
                    pend_last_q <= i_last;
                end
            end
        end
    end

    assign o_ready   = !pending_q;
    assign o_lineImg = img_q;
    assign o_valid   = valid_q;
    assign o_lineEnd = line_end_q;

endmodule

// File: tb/tb_line_packer.sv
// ---------------------------------------------------------------------------
// tb_line_packer
//   Scoreboard bench for line_packer. Each accepted pixel goes into a model
//   word. When that model word closes, the expected word is pushed to a
//   queue. A negedge monitor pops an entry on every output handshake and
//   compares it with the DUT output.
//   Build with +define+LINE_PACK_TAG_EN to expect the pixel-count tag.
// ---------------------------------------------------------------------------
module tb_line_packer;

    localparam int DW  = 24;
    localparam int LW  = 512;
    localparam int PPW = 21;
    localparam int DB  = DW * PPW;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] i_pix;
    logic          i_valid;
    logic          i_last;
    logic          o_ready;
    logic [LW-1:0] o_lineImg;
    logic          o_valid;
    logic          o_lineEnd;
    logic          i_ready;

    line_packer #(.DATA_W(DW), .LINE_W(LW)) dut (
        .clk       (clk),
        .reset     (reset),
        .i_pix     (i_pix),
        .i_valid   (i_valid),
        .i_last    (i_last),
        .o_ready   (o_ready),
        .o_lineImg (o_lineImg),
        .o_valid   (o_valid),
        .o_lineEnd (o_lineEnd),
        .i_ready   (i_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [LW-1:0] img;
        logic          le;
    } exp_t;

    exp_t    sb[$];
    int      hs_edge[$];
    int      n_tests = 0;
    int      n_fail  = 0;
    int      cyc     = 0;
    int      stalls  = 0;
    int      acc_e   = 0;
    logic [DB-1:0] m_data;
    int      m_cnt;
    exp_t    mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_data = '0;
        m_cnt  = 0;
        sb.delete();
    endtask

    task automatic model_accept(input logic [DW-1:0] pix, input logic last);
        exp_t e;
        logic [LW-DB-1:0] tagv;
        m_data[m_cnt*DW +: DW] = pix;
        m_cnt++;
        if (m_cnt == PPW || last) begin
`ifdef LINE_PACK_TAG_EN
            tagv = (LW-DB)'(m_cnt);
`else
            tagv = '0;
`endif
            e.img = {tagv, m_data};
            e.le  = last;
            sb.push_back(e);
            m_data = '0;
            m_cnt  = 0;
        end
    endtask

    // Presents one pixel and holds it until the DUT takes it. Returns the
    // number of the edge that accepted it.
    task automatic send_pix(input logic [DW-1:0] pix, input logic last, output int edge_no);
        logic acc;
        int   guard;
        guard   = 0;
        edge_no = -1;
        i_valid = 1'b1;
        i_pix   = pix;
        i_last  = last;
        forever begin
            acc = o_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                model_accept(pix, last);
                edge_no = cyc;
                break;
            end
            stalls++;
            guard++;
            if (guard > 200) begin
                check("accept_timeout", 1, 0);
                break;
            end
        end
    endtask

    task automatic idle();
        i_valid = 1'b0;
        i_last  = 1'b0;
        i_pix   = '0;
    endtask

    task automatic stream(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) send_pix(base + DW'(i), 1'b0, acc_e);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("drain", sb.size(), 0);
    endtask

    // Pulses reset in the middle of a cycle and checks that the outputs clear
    // at once, without waiting for a clock edge.
    task automatic do_reset(input string tag);
        idle();
        #2 reset = 1'b1;
        #1;
        check({tag, "_valid"}, o_valid, 0);
        check({tag, "_img"}, o_lineImg, 0);
        check({tag, "_le"}, o_lineEnd, 0);
        check({tag, "_ready"}, o_ready, 1);
        model_clear();
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Output monitor: samples half a cycle away from the active edge.
    always @(negedge clk) begin
        if (!reset && o_valid && i_ready) begin
            hs_edge.push_back(cyc + 1);
            if (sb.size() == 0) begin
                check("unexpected_word", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("word", o_lineImg, mon_e.img);
                check("line_end", o_lineEnd, mon_e.le);
            end
        end
    end

    initial begin
        reset   = 1'b0;
        i_ready = 1'b1;
        idle();
        model_clear();

        // Reset state
        #1 reset = 1'b1;
        #1;
        check("rst_valid", o_valid, 0);
        check("rst_img", o_lineImg, 0);
        check("rst_le", o_lineEnd, 0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1;
        check("rst_ready", o_ready, 1);

        // 1: one full word, with latency 1 from the last accept
        hs_edge.delete();
        stream(24'h000001, 21);
        check("t1_valid_lat", o_valid, 1);
        idle();
        drain();
        check("t1_hs_cnt", hs_edge.size(), 1);
        if (hs_edge.size() >= 1) check("t1_hs_edge", hs_edge[0], acc_e + 1);

        // 2: a short word closed by i_last
        for (int i = 0; i < 5; i++) send_pix(24'hA0A0A1 + DW'(i), (i == 4), acc_e);
        idle();
        drain();

        // 3: back-pressure, one word in the output register and one parked
        i_ready = 1'b0;
        stream(24'h300000, 42);
        check("t3_ready_low", o_ready, 0);
        check("t3_valid", o_valid, 1);
        idle();
        hs_edge.delete();
        i_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t3_hs_cnt", hs_edge.size(), 2);
        if (hs_edge.size() >= 2) check("t3_hs_gap", hs_edge[1] - hs_edge[0], 1);
        check("t3_ready_back", o_ready, 1);
        drain();

        // 4: 63 back-to-back pixels give 3 words, 21 clocks apart
        hs_edge.delete();
        stalls = 0;
        stream(24'h400000, 63);
        idle();
        drain();
        check("t4_stalls", stalls, 0);
        check("t4_hs_cnt", hs_edge.size(), 3);
        if (hs_edge.size() >= 3) begin
            check("t4_gap0", hs_edge[1] - hs_edge[0], 21);
            check("t4_gap1", hs_edge[2] - hs_edge[1], 21);
        end

        // 5: the closing pixel and the output handshake land on the same edge
        i_ready = 1'b0;
        stream(24'h500000, 21);
        stream(24'h510000, 20);
        hs_edge.delete();
        stalls  = 0;
        i_ready = 1'b1;
        send_pix(24'h510014, 1'b0, acc_e);
        check("t5_valid_stay", o_valid, 1);
        check("t5_ready", o_ready, 1);
        check("t5_stalls", stalls, 0);
        idle();
        drain();
        check("t5_hs_cnt", hs_edge.size(), 2);
        if (hs_edge.size() >= 2) check("t5_hs_gap", hs_edge[1] - hs_edge[0], 1);

        // 6: reset mid-word, then reset while a word is parked
        stream(24'h600000, 10);
        do_reset("t6a");
        stream(24'h610000, 21);
        idle();
        drain();
        i_ready = 1'b0;
        stream(24'h620000, 42);
        check("t6_pending", o_ready, 0);
        do_reset("t6b");
        i_ready = 1'b1;
        stream(24'h630000, 21);
        idle();
        drain();

        repeat (3) @(posedge clk);
        #1;
        check("final_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
